// File: rtl/girl_motion_ctrl_if.sv
// girl_motion_ctrl_if: frame, key, collision and pixel signals between the girl motion block and its neighbours
interface girl_motion_ctrl_if;
  logic       frame_clk;
  logic       key_left;
  logic       key_right;
  logic       key_jump;
  logic       on_ground;
  logic       hit_ceiling;
  logic [9:0] DrawX;
  logic [9:0] DrawY;
  logic       is_girl;
  logic [9:0] girl_address;
  logic [3:0] girl_status;
  logic [9:0] girl_x;
  logic [9:0] girl_y;
  modport master (
    output frame_clk, key_left, key_right, key_jump, on_ground, hit_ceiling, DrawX, DrawY,
    input  is_girl, girl_address, girl_status, girl_x, girl_y
  );
  modport slave (
    input  frame_clk, key_left, key_right, key_jump, on_ground, hit_ceiling, DrawX, DrawY,
    output is_girl, girl_address, girl_status, girl_x, girl_y
  );
endinterface

// File: rtl/girl_motion_ctrl.sv
// girl_motion_ctrl: per-frame girl position, jump/fall physics, walk status and sprite pixel lookup
module girl_motion_ctrl #(
  parameter int SPRITE_W = 32,
  parameter int SPRITE_H = 32,
  parameter int X_INIT   = 32,
  parameter int Y_INIT   = 416,
  parameter int X_STEP   = 2,
  parameter int JUMP_V   = 8,
  parameter int MAX_FALL = 6
) (
  input logic               Clk,
  input logic               Reset,
  girl_motion_ctrl_if.slave bus
);
  typedef enum logic [1:0] {GROUND, RISE, FALL} state_t;
  localparam logic signed [10:0] X_MAX = 11'(640 - SPRITE_W);
  localparam logic [10:0]        Y_MAX = 11'(480 - SPRITE_H);
  state_t      r_state, w_state;
  logic        r_frame_d;
  logic [9:0]  r_x, r_y, w_x, w_y;
  logic [3:0]  r_vy, w_vy, r_status, w_status, w_vy_dec, w_vy_inc;
  logic        w_tick, w_right, w_left;
  logic signed [10:0] w_dx, w_xs;
  logic [10:0] w_ydn;
  logic [9:0]  w_rx, w_ry;
  assign w_tick   = bus.frame_clk & ~r_frame_d;
  assign w_right  = bus.key_right & ~bus.key_left;
  assign w_left   = bus.key_left & ~bus.key_right;
  assign w_dx     = w_right ? 11'(X_STEP) : w_left ? -11'(X_STEP) : 11'sd0;
  assign w_xs     = $signed({1'b0, r_x}) + w_dx;
  assign w_ydn    = {1'b0, r_y} + {7'b0, r_vy};
  assign w_vy_dec = r_vy - 4'd1;
  assign w_vy_inc = (r_vy >= 4'(MAX_FALL - 1)) ? 4'(MAX_FALL) : r_vy + 4'd1;
  // next position, velocity, vertical state and walk status for a frame tick
  always_comb begin
    w_x      = w_xs < 0 ? 10'd0 : w_xs > X_MAX ? 10'(X_MAX) : w_xs[9:0];
    w_status = w_right ? 4'd1 : w_left ? 4'd2 : 4'd0;
    w_y      = r_y;
    w_vy     = r_vy;
    w_state  = r_state;
    if (r_state == GROUND) begin
      w_state = bus.key_jump ? RISE : !bus.on_ground ? FALL : GROUND;
      w_vy    = bus.key_jump ? 4'(JUMP_V) : !bus.on_ground ? 4'd1 : r_vy;
    end else if (r_state == RISE) begin
      w_state = (bus.hit_ceiling || w_vy_dec == 4'd0) ? FALL : RISE;
      w_vy    = bus.hit_ceiling ? 4'd0 : w_vy_dec;
      w_y     = bus.hit_ceiling ? r_y : (r_y < {6'b0, r_vy}) ? 10'd0 : r_y - {6'b0, r_vy};
    end else begin
      w_state = (bus.on_ground || w_ydn >= Y_MAX) ? GROUND : FALL;
      w_vy    = (bus.on_ground || w_ydn >= Y_MAX) ? 4'd0 : w_vy_inc;
      w_y     = bus.on_ground ? r_y : (w_ydn >= Y_MAX) ? 10'(Y_MAX) : w_ydn[9:0];
    end
  end
  // frame edge history every cycle; motion registers only advance on a frame tick
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_frame_d <= 1'b0;
      r_x       <= 10'(X_INIT);
      r_y       <= 10'(Y_INIT);
      r_vy      <= 4'd0;
      r_state   <= GROUND;
      r_status  <= 4'd0;
    end else begin
      r_frame_d <= bus.frame_clk;
      if (w_tick) begin
        r_x      <= w_x;
        r_y      <= w_y;
        r_vy     <= w_vy;
        r_state  <= w_state;
        r_status <= w_status;
      end
    end
  end
  assign w_rx             = bus.DrawX - r_x;
  assign w_ry             = bus.DrawY - r_y;
  assign bus.is_girl      = ({1'b0, bus.DrawX} >= {1'b0, r_x}) && ({1'b0, bus.DrawX} < {1'b0, r_x} + 11'(SPRITE_W)) &&
                            ({1'b0, bus.DrawY} >= {1'b0, r_y}) && ({1'b0, bus.DrawY} < {1'b0, r_y} + 11'(SPRITE_H));
  assign bus.girl_address = bus.is_girl ? w_ry * 10'(SPRITE_W) + w_rx : 10'd0;
  assign bus.girl_status  = r_status;
  assign bus.girl_x       = r_x;
  assign bus.girl_y       = r_y;
endmodule

// File: tb/tb_girl_motion_ctrl.sv
// tb_girl_motion_ctrl: directed vectors with hand-computed positions for girl_motion_ctrl
module tb_girl_motion_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;
  girl_motion_ctrl_if bus();
  girl_motion_ctrl dut (.Clk(clk), .Reset(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic frame();
    @(negedge clk) bus.frame_clk = 1'b1;
    repeat (2) @(negedge clk);
    bus.frame_clk = 1'b0;
    repeat (2) @(negedge clk);
  endtask
  task automatic pix(input int x, input int y, input int exp_in, input int exp_addr);
    bus.DrawX = 10'(x);
    bus.DrawY = 10'(y);
    #1;
    chk($sformatf("is_girl(%0d,%0d)", x, y), int'(bus.is_girl), exp_in);
    chk($sformatf("addr(%0d,%0d)", x, y), int'(bus.girl_address), exp_addr);
  endtask
  int rise_y[9] = '{408, 401, 395, 390, 386, 383, 381, 380, 380};
  int fall_y[7] = '{381, 383, 386, 390, 395, 401, 407};
  initial begin
    bus.frame_clk = 0; bus.key_left = 0; bus.key_right = 0; bus.key_jump = 0;
    bus.on_ground = 1; bus.hit_ceiling = 0; bus.DrawX = 0; bus.DrawY = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    frame();
    chk("reset_x", int'(bus.girl_x), 32);
    chk("reset_y", int'(bus.girl_y), 416);
    chk("reset_status", int'(bus.girl_status), 0);
    pix(32, 416, 1, 0);
    pix(31, 416, 0, 0);
    pix(63, 447, 1, 1023);
    pix(64, 447, 0, 0);
    pix(32, 448, 0, 0);
    pix(40, 420, 1, 136);
    bus.key_right = 1;
    repeat (3) frame();
    chk("right_x", int'(bus.girl_x), 38);
    chk("right_status", int'(bus.girl_status), 1);
    @(negedge clk) bus.frame_clk = 1'b1;
    repeat (100) @(negedge clk);
    chk("held_frame_x", int'(bus.girl_x), 40);
    bus.frame_clk = 1'b0;
    bus.key_right = 0;
    bus.key_left = 1;
    repeat (19) frame();
    chk("left_x2", int'(bus.girl_x), 2);
    frame();
    chk("left_x0", int'(bus.girl_x), 0);
    chk("left_status", int'(bus.girl_status), 2);
    frame();
    chk("left_nowrap", int'(bus.girl_x), 0);
    bus.key_left = 0;
    bus.key_right = 1;
    frame();
    bus.key_left = 1;
    frame();
    chk("both_x", int'(bus.girl_x), 2);
    chk("both_status", int'(bus.girl_status), 0);
    bus.key_left = 0;
    bus.key_right = 0;
    bus.key_jump = 1;
    bus.on_ground = 0;
    frame();
    chk("jump_start_y", int'(bus.girl_y), 416);
    bus.key_jump = 0;
    for (int i = 0; i < 9; i++) begin
      frame();
      chk($sformatf("rise_%0d", i), int'(bus.girl_y), rise_y[i]);
    end
    for (int i = 0; i < 7; i++) begin
      frame();
      chk($sformatf("fall_%0d", i), int'(bus.girl_y), fall_y[i]);
    end
    bus.on_ground = 1;
    repeat (2) frame();
    chk("landed_y", int'(bus.girl_y), 407);
    bus.key_jump = 1;
    frame();
    bus.key_jump = 0;
    bus.on_ground = 0;
    frame();
    chk("rise2_y", int'(bus.girl_y), 399);
    bus.hit_ceiling = 1;
    frame();
    chk("ceiling_y", int'(bus.girl_y), 399);
    bus.hit_ceiling = 0;
    frame();
    chk("after_ceiling_y0", int'(bus.girl_y), 399);
    frame();
    chk("after_ceiling_y1", int'(bus.girl_y), 400);
    frame();
    chk("after_ceiling_y2", int'(bus.girl_y), 402);
    repeat (9) frame();
    chk("bottom_clamp_y", int'(bus.girl_y), 448);
    bus.on_ground = 1;
    frame();
    chk("bottom_ground_y", int'(bus.girl_y), 448);
    bus.key_jump = 1;
    frame();
    bus.key_jump = 0;
    bus.on_ground = 0;
    bus.key_right = 1;
    repeat (2) frame();
    chk("mid_jump_y", int'(bus.girl_y), 433);
    @(negedge clk) rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    chk("midreset_x", int'(bus.girl_x), 32);
    chk("midreset_y", int'(bus.girl_y), 416);
    chk("midreset_status", int'(bus.girl_status), 0);
    bus.key_right = 0;
    bus.on_ground = 1;
    frame();
    chk("post_reset_ground_y", int'(bus.girl_y), 416);
    bus.on_ground = 0;
    frame();
    frame();
    chk("post_reset_fall_y", int'(bus.girl_y), 417);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/girl_motion_ctrl.md
Name: girl_motion_ctrl

Overview:
- Upstream neighbour of the colour mapper: owns the girl character's position, jump/fall physics and walk status.
- Produces `is_girl`, `girl_address` (32x32 sprite ROM index) and `girl_status` for the current pixel, which the colour mapper consumes.
- Motion advances once per video frame, on the rising edge of `frame_clk` (VGA vsync), sampled in the `Clk` domain.
- Collision against the map is supplied by an external collision block as per-frame flags.

Parameters:
- SPRITE_W, 32, sprite width in pixels (address stride)
- SPRITE_H, 32, sprite height in pixels
- X_INIT, 32, reset X of sprite top-left corner
- Y_INIT, 416, reset Y of sprite top-left corner
- X_STEP, 2, horizontal pixels moved per frame while a walk key is held
- JUMP_V, 8, initial upward velocity (pixels/frame) at jump start
- MAX_FALL, 6, maximum downward velocity (pixels/frame)

Ports:
- Clk  in  1  system clock (50 MHz)
- Reset  in  1  synchronous, active-high reset
- frame_clk  in  1  VGA vsync; a rising edge marks a frame boundary
- key_left  in  1  walk-left key held
- key_right  in  1  walk-right key held
- key_jump  in  1  jump key held
- on_ground  in  1  collision: solid pixel directly below the sprite
- hit_ceiling  in  1  collision: solid pixel directly above the sprite
- DrawX  in  10  current pixel X
- DrawY  in  10  current pixel Y
- is_girl  out  1  current pixel lies inside the sprite box
- girl_address  out  10  sprite ROM index for the current pixel
- girl_status  out  4  0=idle, 1=walking right, 2=walking left
- girl_x  out  10  sprite top-left X (registered)
- girl_y  out  10  sprite top-left Y (registered)

Behaviour:
- Clocking and reset
  - One clock, `Clk`. Reset is synchronous and active-high.
  - On reset: girl_x=X_INIT, girl_y=Y_INIT, vy=0, state=GROUND, girl_status=0, frame_clk history register=0.
  - Reset asserted mid-jump restores these values on the next edge.
- Frame tick
  - frame_tick = frame_clk & ~frame_clk_d, using one registered copy.
  - frame_tick is high for exactly one Clk cycle per frame.
  - All position, velocity, state and status updates happen only on Clk edges where frame_tick=1. Otherwise all registers hold.
- Horizontal motion (per tick)
  - key_right only: x += X_STEP, girl_status=1.
  - key_left only: x -= X_STEP, girl_status=2.
  - Neither key, or both keys: x unchanged, girl_status=0.
  - Clamp x to [0, 640-SPRITE_W]. Compute in 11-bit signed so that x - X_STEP near 0 does not wrap.
- Vertical state machine (per tick); vy is a 4-bit unsigned magnitude
  - GROUND:
    - key_jump=1 → RISE, vy=JUMP_V. y does not change on this tick.
    - else on_ground=0 → FALL, vy=1.
    - else stay in GROUND.
  - RISE:
    - hit_ceiling=1 → FALL, vy=0. No y change on this tick.
    - else y -= vy, then vy -= 1. When the decremented vy reaches 0 → FALL.
    - Clamp y ≥ 0.
  - FALL:
    - on_ground=1 → GROUND, vy=0. No y change on this tick.
    - else y += vy, then vy = min(vy+1, MAX_FALL).
    - Clamp y ≤ 480-SPRITE_H. Reaching the clamp → GROUND, vy=0, even if on_ground=0.
  - key_jump held continuously re-triggers a jump on the first tick after landing (no edge requirement).
  - Simultaneous horizontal and vertical updates apply on the same tick.
- Pixel outputs: combinational from DrawX, DrawY, girl_x, girl_y
  - is_girl = (DrawX ≥ girl_x) & (DrawX < girl_x+SPRITE_W) & (DrawY ≥ girl_y) & (DrawY < girl_y+SPRITE_H). Comparisons are 11-bit.
  - girl_address = (DrawY-girl_y)*SPRITE_W + (DrawX-girl_x), truncated to 10 bits.
  - girl_address is 0 when is_girl=0.
  - girl_status is registered.
  - girl_x and girl_y are the registered position.

Test Plan:
- Reset held 2 cycles, then released with frame_clk toggling → girl_x=32, girl_y=416, girl_status=0, is_girl=1 only for DrawX∈[32,63], DrawY∈[416,447]; girl_address at (40,420) = 4*32+8 = 136.
- key_right held for 3 frame ticks, on_ground=1 → girl_x=38, girl_status=1; frame_clk held high for 100 Clk cycles produces no extra movement.
- Starting from x=2, key_left held 2 ticks → girl_x=0 after the first tick and stays 0, no wrap; both keys held → girl_x unchanged, girl_status=0.
- key_jump pulsed for 1 tick, on_ground forced 0 in the air → y sequence over ticks: 416, 408, 401, 395, 390, 386, 383, 381, 380, 380 (apex, enters FALL); then falls by 1, 2, 3, … up to 6 per tick; on_ground=1 → GROUND, vy=0, y frozen.
- In RISE at y=300, hit_ceiling=1 on one tick → state FALL, y stays 300 that tick, next tick y=301.
- Reset asserted mid-fall (y=350, vy=4) → next cycle girl_y=416, state GROUND, vy=0.
